pad_input_conditioner: RTL and testbench

PAD_INPUT_CONDITIONER -- requirements
Module: pad_input_conditioner

---
 rtl/pad_cond_pkg.sv | 13 +
 rtl/sync_2ff.sv | 24 ++
 rtl/pad_input_conditioner.sv | 87 ++++++++
 tb/tb_pad_input_conditioner.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pad_cond_pkg.sv
// Shared widths and helpers for pad input conditioning.
package pad_cond_pkg;

    localparam int unsigned FILT_W_DEF = 4;
    localparam int unsigned GLITCH_W   = 8;
    localparam logic [GLITCH_W-1:0] GLITCH_MAX = GLITCH_W'(255);

    // Increment a glitch count, holding at GLITCH_MAX instead of wrapping.
    function automatic logic [GLITCH_W-1:0] glitch_sat_inc(input logic [GLITCH_W-1:0] cur);
        glitch_sat_inc = (cur == GLITCH_MAX) ? cur : cur + GLITCH_W'(1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with a selectable reset level, for asynchronous pad inputs.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pad_input_conditioner.sv
// Synchronizes a pad input, rejects pulses shorter than filt_len+1 clocks,
// reports accepted edges and counts rejected pulses.
module pad_input_conditioner
    import pad_cond_pkg::*;
#(
    parameter int unsigned FILT_W    = FILT_W_DEF,
    parameter logic        RST_LEVEL = 1'b0
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                pad_z,
    input  logic                en,
    input  logic [FILT_W-1:0]   filt_len,
    input  logic                glitch_clr,
    output logic                data_out,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    logic                sync;
    logic [FILT_W-1:0]   cnt;
    logic [FILT_W-1:0]   cnt_nxt;
    logic                data_nxt;
    logic                rise_nxt;
    logic                fall_nxt;
    logic [GLITCH_W-1:0] glitch_nxt;

    sync_2ff #(
        .RST_VAL (RST_LEVEL)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (pad_z),
        .q    (sync)
    );

    // Filter decision: count a differing level, accept it once stable long
    // enough, or drop a short pulse and record it as a glitch.
    always_comb begin
        cnt_nxt    = cnt;
        data_nxt   = data_out;
        rise_nxt   = 1'b0;
        fall_nxt   = 1'b0;
        glitch_nxt = glitch_cnt;

        if (!en) begin
            cnt_nxt = '0;
        end else if (sync != data_out) begin
            // cnt < filt_len here, so the increment can never wrap.
            if (cnt >= filt_len) begin
                data_nxt = sync;
                cnt_nxt  = '0;
                rise_nxt = sync;
                fall_nxt = ~sync;
            end else begin
                cnt_nxt = cnt + FILT_W'(1);
            end
        end else if (cnt != '0) begin
            cnt_nxt    = '0;
            glitch_nxt = glitch_sat_inc(glitch_cnt);
        end

        // Clear wins over a simultaneous glitch increment.
        if (glitch_clr) begin
            glitch_nxt = '0;
        end
    end

    // Filter state and registered outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt        <= '0;
            data_out   <= RST_LEVEL;
            rise       <= 1'b0;
            fall       <= 1'b0;
            glitch_cnt <= '0;
        end else begin
            cnt        <= cnt_nxt;
            data_out   <= data_nxt;
            rise       <= rise_nxt;
            fall       <= fall_nxt;
            glitch_cnt <= glitch_nxt;
        end
    end

endmodule

// File: tb/tb_pad_input_conditioner.sv
// Bench for pad_input_conditioner: two instances (reset level 0 and 1) share
// stimulus and are checked every cycle against a run-length reference model.
module tb_pad_input_conditioner;

    logic       clk = 1'b0;
    logic       rstn;
    logic       pad_z;
    logic       en;
    logic [3:0] filt_len;
    logic       glitch_clr;

    logic       d0, r0, f0;
    logic [7:0] g0;
    logic       d1, r1, f1;
    logic [7:0] g1;

    int vectors     = 0;
    int miscompares = 0;

    // Reference state per instance: [0] reset level 0, [1] reset level 1.
    bit ms1[2];
    bit ms2[2];
    bit mdout[2];
    bit mrise[2];
    bit mfall[2];
    int mrun[2];
    int mgl[2];

    always #5 clk = ~clk;

    pad_input_conditioner #(.FILT_W(4), .RST_LEVEL(1'b0)) dut0 (
        .clk(clk), .rstn(rstn), .pad_z(pad_z), .en(en), .filt_len(filt_len),
        .glitch_clr(glitch_clr), .data_out(d0), .rise(r0), .fall(f0), .glitch_cnt(g0)
    );

    pad_input_conditioner #(.FILT_W(4), .RST_LEVEL(1'b1)) dut1 (
        .clk(clk), .rstn(rstn), .pad_z(pad_z), .en(en), .filt_len(filt_len),
        .glitch_clr(glitch_clr), .data_out(d1), .rise(r1), .fall(f1), .glitch_cnt(g1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            ms1[i]   = (i == 1);
            ms2[i]   = (i == 1);
            mdout[i] = (i == 1);
            mrise[i] = 1'b0;
            mfall[i] = 1'b0;
            mrun[i]  = 0;
            mgl[i]   = 0;
        end
    endtask

    // One clock of the reference: the level the filter sees is the pad two
    // samples ago; a new level is taken after filt_len+1 consecutive sightings.
    task automatic model_edge();
        bit sy;
        for (int i = 0; i < 2; i++) begin
            sy       = ms2[i];
            mrise[i] = 1'b0;
            mfall[i] = 1'b0;
            if (!en) begin
                mrun[i] = 0;
            end else if (sy != mdout[i]) begin
                if (mrun[i] >= int'(filt_len)) begin
                    mdout[i] = sy;
                    mrun[i]  = 0;
                    if (sy) mrise[i] = 1'b1;
                    else    mfall[i] = 1'b1;
                end else begin
                    mrun[i] = mrun[i] + 1;
                end
            end else if (mrun[i] != 0) begin
                mrun[i] = 0;
                if (mgl[i] < 255) mgl[i] = mgl[i] + 1;
            end
            if (glitch_clr) mgl[i] = 0;
            ms2[i] = ms1[i];
            ms1[i] = pad_z;
        end
    endtask

    task automatic check_all();
        check("d0_data", 8'(d0), 8'(mdout[0]));
        check("d0_rise", 8'(r0), 8'(mrise[0]));
        check("d0_fall", 8'(f0), 8'(mfall[0]));
        check("d0_glit", g0, 8'(mgl[0]));
        check("d1_data", 8'(d1), 8'(mdout[1]));
        check("d1_rise", 8'(r1), 8'(mrise[1]));
        check("d1_fall", 8'(f1), 8'(mfall[1]));
        check("d1_glit", g1, 8'(mgl[1]));
        check("rf_excl", 8'(r0 & f0) | 8'(r1 & f1), 8'(0));
    endtask

    // Advance one clock, update the model, and check 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        if (!rstn) model_reset();
        else       model_edge();
        #1;
        check_all();
    endtask

    // Clocks until the selected instance's data_out changes; -1 on timeout.
    task automatic measure(input int which, output int n);
        logic start;
        logic cur;
        start = (which == 1) ? d1 : d0;
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            cur = (which == 1) ? d1 : d0;
            if (cur != start) begin
                n = k;
                break;
            end
        end
    endtask

    initial begin
        int n;
        rstn       = 1'b0;
        pad_z      = 1'b0;
        en         = 1'b1;
        filt_len   = 4'd0;
        glitch_clr = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check_all();
        rstn = 1'b1;
        repeat (6) step();

        // filt_len=0: 3-clock latency, one-cycle rise
        pad_z = 1'b1;
        measure(0, n);
        check("lat_l0", 8'(n), 8'(3));
        check("rise_l0", 8'(r0), 8'(1));
        step();
        check("rise_l0_end", 8'(r0), 8'(0));
        repeat (3) step();

        // filt_len=4: falling acceptance takes 7 clocks
        filt_len = 4'd4;
        pad_z    = 1'b0;
        measure(0, n);
        check("lat_l4_fall", 8'(n), 8'(7));
        check("fall_l4", 8'(f0), 8'(1));
        repeat (4) step();

        // Short pulse rejected and counted
        pad_z = 1'b1;
        repeat (4) step();
        pad_z = 1'b0;
        repeat (6) step();
        check("pulse_data", 8'(d0), 8'(0));
        check("pulse_glit", g0, 8'(1));

        // Long pulse accepted after 7 clocks
        pad_z = 1'b1;
        measure(0, n);
        check("lat_l4_rise", 8'(n), 8'(7));
        check("rise_l4", 8'(r0), 8'(1));
        repeat (4) step();

        // 300 short glitches saturate the counter
        for (int i = 0; i < 300; i++) begin
            pad_z = 1'b0;
            step();
            pad_z = 1'b1;
            repeat (3) step();
        end
        check("glit_sat", g0, 8'(255));
        check("glit_sat_data", 8'(d0), 8'(1));

        // Clear on the same edge as a further glitch increment
        pad_z = 1'b0;
        step();
        pad_z = 1'b1;
        step();
        step();
        check("glit_pre_clr", g0, 8'(255));
        glitch_clr = 1'b1;
        step();
        glitch_clr = 1'b0;
        check("glit_clr_wins", g0, 8'(0));
        pad_z = 1'b0;
        step();
        pad_z = 1'b1;
        repeat (3) step();
        check("glit_after_clr", g0, 8'(1));

        // Disabled filter holds through a pad change, then accepts after filt_len+1
        en    = 1'b0;
        pad_z = 1'b0;
        repeat (8) step();
        check("dis_hold", 8'(d0), 8'(1));
        en = 1'b1;
        measure(0, n);
        check("reen_lat", 8'(n), 8'(5));
        check("reen_fall", 8'(f0), 8'(1));
        repeat (2) step();

        // Reset mid-count with RST_LEVEL=1
        pad_z = 1'b1;
        measure(0, n);
        check("pre_rst_rise", 8'(n), 8'(7));
        repeat (3) step();
        pad_z = 1'b0;
        repeat (4) step();
        #1;
        rstn = 1'b0;
        #1;
        model_reset();
        check("rst_async_d1", 8'(d1), 8'(1));
        check("rst_async_d0", 8'(d0), 8'(0));
        check_all();
        step();
        rstn = 1'b1;
        measure(1, n);
        check("rst_rel_lat", 8'(n), 8'(7));
        check("rst_rel_fall", 8'(f1), 8'(1));
        check("rst_rel_glit", g1, 8'(0));
        repeat (3) step();

        // Randomized traffic, including filt_len changes mid-count
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 3) == 0) pad_z = ~pad_z;
            en         = ($urandom_range(0, 15) != 0);
            glitch_clr = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 15) == 0) filt_len = 4'($urandom_range(0, 6));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
